clk_en_div_prog: RTL and testbench

- Parametrised, runtime-programmable clock-enable generator. Successor to the fixed divide-by-16 flag generator.
- Produces a one-cycle `flag` strobe every D clocks and a square-wave `level` qualifier. Both are registered and stay in the `clk` domain; neither is ever used as a clock.
- D is loaded at runtime through a shadow register. A new D takes effect only on a period boundary, so no runt periods occur.
- Sits between system clock and slow peripherals (UART baud tick, LED scan, debounce sampling) as a shared enable source.

---
 rtl/clk_en_div_prog_pkg.sv | 17 +
 rtl/div_shadow_ctl.sv | 63 ++++++
 rtl/clk_en_div_prog.sv | 83 ++++++++
 tb/tb_clk_en_div_prog.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/clk_en_div_prog_pkg.sv
// Shared definitions for the programmable clock-enable divider.
//   CNT_W_DEF   : default counter/divisor width
//   DIV_MIN     : smallest divisor ever placed in force (a load of 0 becomes this)
//   apply_src_e : which condition opened the divisor-apply window this cycle
package clk_en_div_prog_pkg;

   localparam int CNT_W_DEF = 16;
   localparam int DIV_MIN   = 1;

   typedef enum logic [1:0] {
      APPLY_NONE = 2'd0,
      APPLY_TC   = 2'd1,
      APPLY_IDLE = 2'd2,
      APPLY_CLR  = 2'd3
   } apply_src_e;

endpackage

// File: rtl/div_shadow_ctl.sv
// Divisor shadow register and apply control.
//   clk, rst        : system clock, synchronous active-high reset
//   en, clr, tc     : counter enable, period restart, terminal count
//   div_val         : requested divisor (0 is clamped to DIV_MIN)
//   div_load        : one-cycle capture request
//   div_active      : divisor in force
//   div_pending     : a captured divisor waits for a period boundary
//   apply           : strobe, div_active changes on this edge (counter must restart)
module div_shadow_ctl
   import clk_en_div_prog_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int DIV_DEFAULT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             tc,
   input  logic [CNT_W-1:0] div_val,
   input  logic             div_load,
   output logic [CNT_W-1:0] div_active,
   output logic             div_pending,
   output logic             apply
);

   logic [CNT_W-1:0] shadow;
   logic [CNT_W-1:0] div_clamped;
   apply_src_e       src;

   always_comb begin
      src = APPLY_NONE;
      if (clr)
         src = APPLY_CLR;
      else if (!en)
         src = APPLY_IDLE;
      else if (tc)
         src = APPLY_TC;
   end

   assign div_clamped = (div_val == '0) ? CNT_W'(DIV_MIN) : div_val;

   // A load arriving inside an apply window bypasses the shadow and goes live at once.
   assign apply = (src != APPLY_NONE) && (div_load || div_pending);

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow      <= '0;
         div_active  <= CNT_W'(DIV_DEFAULT);
         div_pending <= 1'b0;
      end else begin
         if (div_load)
            shadow <= div_clamped;
         if (apply) begin
            div_active  <= div_load ? div_clamped : shadow;
            div_pending <= 1'b0;
         end else if (div_load) begin
            div_pending <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/clk_en_div_prog.sv
// Runtime-programmable clock-enable generator.
//   clk, rst    : system clock, synchronous active-high reset
//   en          : count enable (low freezes the counter)
//   clr         : restart the current period
//   div_val     : new divisor, captured when div_load=1
//   div_load    : one-cycle capture request
//   flag        : one-cycle strobe every D cycles
//   level       : square wave, high ceil(D/2) / low floor(D/2) cycles
//   cnt         : current count 0..D-1
//   div_active  : divisor in force (D)
//   div_pending : a loaded divisor waits for the period boundary
module clk_en_div_prog
   import clk_en_div_prog_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int DIV_DEFAULT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [CNT_W-1:0] div_val,
   input  logic             div_load,
   output logic             flag,
   output logic             level,
   output logic [CNT_W-1:0] cnt,
   output logic [CNT_W-1:0] div_active,
   output logic             div_pending
);

   logic             tc;
   logic             apply;
   logic [CNT_W-1:0] cnt_next;
   logic [CNT_W-1:0] half;

   // div_active is never 0, so D-1 cannot underflow.
   assign tc   = (cnt == div_active - 1'b1);
   assign half = (div_active >> 1) + {{(CNT_W-1){1'b0}}, div_active[0]};

   // An apply with en=1 always coincides with tc, so the restart to 0 covers both.
   always_comb begin
      cnt_next = cnt + 1'b1;
      if (tc)
         cnt_next = '0;
   end

   div_shadow_ctl #(
      .CNT_W       (CNT_W),
      .DIV_DEFAULT (DIV_DEFAULT)
   ) u_shadow (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .clr         (clr),
      .tc          (tc),
      .div_val     (div_val),
      .div_load    (div_load),
      .div_active  (div_active),
      .div_pending (div_pending),
      .apply       (apply)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         flag  <= 1'b0;
         level <= 1'b0;
      end else if (clr) begin
         cnt   <= '0;
         flag  <= 1'b0;
         level <= 1'b1;
      end else if (en) begin
         cnt   <= cnt_next;
         flag  <= tc;
         level <= (cnt_next < half);
      end else begin
         flag <= 1'b0;
         if (apply)
            cnt <= '0;
      end
   end

endmodule

// File: tb/tb_clk_en_div_prog.sv
module tb_clk_en_div_prog;

   localparam int W   = 16;
   localparam int DEF = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic         clr = 1'b0;
   logic [W-1:0] div_val = '0;
   logic         div_load = 1'b0;
   logic         flag, level, div_pending;
   logic [W-1:0] cnt, div_active;

   int checks = 0;
   int errors = 0;
   bit done = 1'b0;

   typedef struct {
      bit flag;
      bit level;
      int cnt;
      int d;
      bit pend;
   } exp_t;

   exp_t sb[$];

   clk_en_div_prog #(.CNT_W(W), .DIV_DEFAULT(DEF)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .clr         (clr),
      .div_val     (div_val),
      .div_load    (div_load),
      .flag        (flag),
      .level       (level),
      .cnt         (cnt),
      .div_active  (div_active),
      .div_pending (div_pending)
   );

   always #5 clk = ~clk;

   // Reference model: phase within a period of length d, with a queued divisor.
   int m_cnt = 0, m_d = DEF, m_sh = 0;
   bit m_pend = 0, m_flag = 0, m_lvl = 0;

   always @(posedge clk) begin
      exp_t e;
      int   req;
      bit   at_end, window, take;
      if (rst) begin
         m_cnt = 0; m_d = DEF; m_sh = 0; m_pend = 0; m_flag = 0; m_lvl = 0;
      end else begin
         req    = (div_val == 0) ? 1 : int'(div_val);
         at_end = (m_cnt == m_d - 1);
         window = clr || !en || at_end;
         take   = window && (div_load || m_pend);
         if (clr) begin
            m_cnt = 0; m_flag = 0; m_lvl = 1;
         end else if (en) begin
            m_flag = at_end;
            m_cnt  = (m_cnt + 1) % m_d;
         end else begin
            m_flag = 0;
            if (take) m_cnt = 0;
         end
         if (take) begin
            m_d    = div_load ? req : m_sh;
            m_pend = 0;
         end else if (div_load) begin
            m_pend = 1;
         end
         if (div_load) m_sh = req;
         if (!clr && en) m_lvl = (m_cnt < (m_d + 1) / 2);
      end
      e.flag = m_flag; e.level = m_lvl; e.cnt = m_cnt; e.d = m_d; e.pend = m_pend;
      sb.push_back(e);
   end

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
      end
   endtask

   // Monitor: the DUT presents a fresh output set after every edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("flag", int'(flag), int'(e.flag));
         chk("level", int'(level), int'(e.level));
         chk("cnt", int'(cnt), e.cnt);
         chk("div_active", int'(div_active), e.d);
         chk("div_pending", int'(div_pending), int'(e.pend));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input int v);
      div_val  = W'(v);
      div_load = 1'b1;
      @(negedge clk);
      div_load = 1'b0;
   endtask

   task automatic wait_cnt(input int v);
      for (int i = 0; i < 300; i++) begin
         if (int'(cnt) == v) return;
         @(negedge clk);
      end
      checks++;
      errors++;
      $display("FAIL wait_cnt timeout: cnt=%0d target=%0d", cnt, v);
   endtask

   initial begin
      cyc(3);
      rst = 1'b0;
      en  = 1'b1;
      cyc(50);
      // load 5 early in a D=16 period
      wait_cnt(3);
      load(5);
      cyc(30);
      // freeze at cnt=2 of the D=5 period
      wait_cnt(2);
      en = 1'b0;
      cyc(10);
      en = 1'b1;
      cyc(12);
      // divisor 0 clamps to 1
      load(0);
      cyc(10);
      // D=4, then a load coincident with TC
      load(4);
      cyc(2);
      wait_cnt(3);
      load(3);
      cyc(8);
      // two loads in one period, last wins
      wait_cnt(0);
      load(6);
      load(9);
      cyc(25);
      // reset mid-period with a pending load
      load(16);
      cyc(10);
      wait_cnt(11);
      load(7);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      cyc(20);
      // clr with a pending divisor, and en=0 applies
      load(3);
      clr = 1'b1; cyc(1); clr = 1'b0;
      cyc(6);
      load(8);
      en = 1'b0; cyc(3); en = 1'b1;
      cyc(10);
      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         en       = ($urandom_range(0, 7) != 0);
         clr      = ($urandom_range(0, 40) == 0);
         rst      = ($urandom_range(0, 400) == 0);
         div_load = ($urandom_range(0, 25) == 0);
         div_val  = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 40))
                                                  : W'($urandom_range(0, 10));
         @(negedge clk);
      end
      rst = 1'b0; clr = 1'b0; div_load = 1'b0; en = 1'b1;
      cyc(3);
      done = 1'b1;
   end

   initial begin
      fork
         wait (done);
         #2000000;
      join_any
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL global timeout");
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
